// File: rtl/romix_sched_pkg.sv
// rtl/romix_sched_pkg.sv - shared constants, FSM states and start decode for the ROMix core scheduler
package romix_sched_pkg;

    localparam int NUM_CORES = 32;
    localparam int IDX_W     = 5;
    localparam int TAG_W     = 32;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_ISSUE = 1'b1;

    // Decode a core index into its one-hot start vector
    function automatic logic [NUM_CORES-1:0] onehot_from_idx(input logic [IDX_W-1:0] idx);
        logic [NUM_CORES-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_pick_32.sv
// rtl/rr_pick_32.sv - round-robin pick of the first free core above ptr, wrapping 31->0
module rr_pick_32
    import romix_sched_pkg::*;
(
    input  logic [NUM_CORES-1:0] free_set,
    input  logic [IDX_W-1:0]     ptr,
    output logic [IDX_W-1:0]     sel,
    output logic                 any
);

    logic [IDX_W-1:0]     start;
    logic [NUM_CORES-1:0] rot;
    logic [IDX_W-1:0]     k;

    // Rotate so ptr+1 lands at bit 0, find the lowest set bit, then rotate the index back
    always_comb begin
        start = ptr + 5'd1;
        rot   = 32'({free_set, free_set} >> start);
        k     = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (rot[i]) begin
                k = i[IDX_W-1:0];
            end
        end
        sel = start + k;
        any = |free_set;
    end

endmodule

// File: rtl/romix_core_scheduler.sv
// rtl/romix_core_scheduler.sv - round-robin job dispatch onto 32 ROMix cores; ROMIX_SCHED_PERF_EN adds job counters
module romix_core_scheduler
    import romix_sched_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 job_valid,
    output logic                 job_ready,
    input  logic [TAG_W-1:0]     job_tag,
    input  logic [NUM_CORES-1:0] core_en_mask,
    input  logic                 drain,
    output logic [NUM_CORES-1:0] core_start,
    output logic [TAG_W-1:0]     core_tag,
    output logic [IDX_W-1:0]     core_sel,
    input  logic [NUM_CORES-1:0] core_done,
    output logic [NUM_CORES-1:0] busy,
    output logic                 idle,
    output logic                 err_spurious_done
`ifdef ROMIX_SCHED_PERF_EN
    ,
    output logic [31:0]          jobs_issued,
    output logic [31:0]          jobs_done
`endif
);

    logic [0:0]           state;
    logic [IDX_W-1:0]     ptr;
    logic [NUM_CORES-1:0] free_set;
    logic [IDX_W-1:0]     pick_sel;
    logic                 pick_any;
    logic                 accept;
    logic                 issue;

    assign free_set   = ~busy & core_en_mask;
    assign issue      = (state == S_ISSUE);
    assign job_ready  = ~rst & (state == S_IDLE) & pick_any & ~drain;
    assign accept     = job_valid & job_ready;
    assign core_start = issue ? onehot_from_idx(core_sel) : '0;
    assign idle       = (state == S_IDLE) & ~(|busy);

    rr_pick_32 u_pick (
        .free_set (free_set),
        .ptr      (ptr),
        .sel      (pick_sel),
        .any      (pick_any)
    );

    // Accept latches tag and chosen core; the issue cycle advances the round-robin pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            ptr      <= 5'd31;
            core_tag <= '0;
            core_sel <= '0;
        end else if (accept) begin
            state    <= S_ISSUE;
            core_tag <= job_tag;
            core_sel <= pick_sel;
        end else if (issue) begin
            state    <= S_IDLE;
            ptr      <= core_sel;
        end
    end

    // Busy tracking: done clears, start sets (start wins); a done on an idle core latches the error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy              <= '0;
            err_spurious_done <= 1'b0;
        end else begin
            busy <= (busy & ~core_done) | core_start;
            if (|(core_done & ~busy)) begin
                err_spurious_done <= 1'b1;
            end
        end
    end

`ifdef ROMIX_SCHED_PERF_EN
    logic [NUM_CORES-1:0] valid_done;
    logic [31:0]          done_cnt;

    // Count only completions from cores that were actually busy
    always_comb begin
        valid_done = core_done & busy;
        done_cnt   = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            done_cnt = done_cnt + {31'd0, valid_done[i]};
        end
    end

    // Free-running wrap-around job counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            jobs_issued <= '0;
            jobs_done   <= '0;
        end else begin
            if (issue) begin
                jobs_issued <= jobs_issued + 32'd1;
            end
            jobs_done <= jobs_done + done_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_romix_core_scheduler.sv
// tb/tb_romix_core_scheduler.sv - cycle-table and directed checks for romix_core_scheduler
module tb_romix_core_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        job_valid;
    logic        job_ready;
    logic [31:0] job_tag;
    logic [31:0] core_en_mask;
    logic        drain;
    logic [31:0] core_start;
    logic [31:0] core_tag;
    logic [4:0]  core_sel;
    logic [31:0] core_done;
    logic [31:0] busy;
    logic        idle;
    logic        err_spurious_done;
`ifdef ROMIX_SCHED_PERF_EN
    logic [31:0] jobs_issued;
    logic [31:0] jobs_done;
`endif

    romix_core_scheduler dut (
        .clk               (clk),
        .rst               (rst),
        .job_valid         (job_valid),
        .job_ready         (job_ready),
        .job_tag           (job_tag),
        .core_en_mask      (core_en_mask),
        .drain             (drain),
        .core_start        (core_start),
        .core_tag          (core_tag),
        .core_sel          (core_sel),
        .core_done         (core_done),
        .busy              (busy),
        .idle              (idle),
        .err_spurious_done (err_spurious_done)
`ifdef ROMIX_SCHED_PERF_EN
        ,
        .jobs_issued       (jobs_issued),
        .jobs_done         (jobs_done)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        jv;
        logic [31:0] tag;
        logic [31:0] mask;
        logic        drn;
        logic [31:0] done;
        logic        e_rdy;
        logic [31:0] e_start;
        logic [4:0]  e_sel;
        logic [31:0] e_tag;
        logic [31:0] e_busy;
        logic        e_idle;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    localparam logic [31:0] M = 32'hFFFF_FFFF;

    task automatic add(input logic r, input logic jv, input logic [31:0] tag, input logic [31:0] mask,
                       input logic drn, input logic [31:0] done, input logic e_rdy, input logic [31:0] e_start,
                       input logic [4:0] e_sel, input logic [31:0] e_tag, input logic [31:0] e_busy,
                       input logic e_idle, input logic e_err);
        vec_t v;
        v.rst = r; v.jv = jv; v.tag = tag; v.mask = mask; v.drn = drn; v.done = done;
        v.e_rdy = e_rdy; v.e_start = e_start; v.e_sel = e_sel; v.e_tag = e_tag;
        v.e_busy = e_busy; v.e_idle = e_idle; v.e_err = e_err;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_vec(input int idx, input vec_t v);
        logic bad;
        bad = (job_ready !== v.e_rdy) || (core_start !== v.e_start) || (busy !== v.e_busy) ||
              (idle !== v.e_idle) || (err_spurious_done !== v.e_err);
        if (v.e_start != 32'd0) begin
            bad = bad || (core_sel !== v.e_sel) || (core_tag !== v.e_tag);
        end
        n_vec++;
        if (bad) begin
            n_bad++;
            $display("FAIL vec%0d: ready %b/%b start %h/%h sel %0d/%0d tag %h/%h busy %h/%h idle %b/%b err %b/%b (got/expected)",
                     idx, job_ready, v.e_rdy, core_start, v.e_start, core_sel, v.e_sel, core_tag, v.e_tag,
                     busy, v.e_busy, idle, v.e_idle, err_spurious_done, v.e_err);
        end
    endtask

    initial begin
        // three back-to-back jobs from reset, then release them
        add(0,1,32'hA0,M,0,0,            1,0,0,0,          0,1,0);
        add(0,1,32'hA1,M,0,0,            0,32'h1,0,32'hA0, 0,0,0);
        add(0,1,32'hA1,M,0,0,            1,0,0,0,          32'h1,0,0);
        add(0,1,32'hA2,M,0,0,            0,32'h2,1,32'hA1, 32'h1,0,0);
        add(0,1,32'hA2,M,0,0,            1,0,0,0,          32'h3,0,0);
        add(0,0,0,M,0,0,                 0,32'h4,2,32'hA2, 32'h3,0,0);
        add(0,0,0,M,0,0,                 1,0,0,0,          32'h7,0,0);
        add(0,0,0,M,0,32'h7,             1,0,0,0,          32'h7,0,0);
        add(0,0,0,M,0,0,                 1,0,0,0,          0,1,0);
        // masked low nibble after reset -> core 4
        add(1,0,0,M,0,0,                 0,0,0,0,          0,1,0);
        add(0,1,32'hB0,32'hFFFFFFF0,0,0, 1,0,0,0,          0,1,0);
        add(0,0,0,32'hFFFFFFF0,0,0,      0,32'h10,4,32'hB0, 0,0,0);
        add(0,0,0,32'hFFFFFFF0,0,0,      1,0,0,0,          32'h10,0,0);
        add(0,0,0,32'hFFFFFFF0,0,32'h10, 1,0,0,0,          32'h10,0,0);
        add(0,0,0,32'hFFFFFFF0,0,0,      1,0,0,0,          0,1,0);
        // wrap: ptr=30, free {31,2}
        add(1,0,0,32'h40000000,0,0,      0,0,0,0,          0,1,0);
        add(0,1,32'hC0,32'h40000000,0,0, 1,0,0,0,          0,1,0);
        add(0,0,0,32'h40000000,0,0,      0,32'h40000000,30,32'hC0, 0,0,0);
        add(0,1,32'hC1,32'h80000004,0,0, 1,0,0,0,          32'h40000000,0,0);
        add(0,0,0,32'h80000004,0,0,      0,32'h80000000,31,32'hC1, 32'h40000000,0,0);
        add(0,1,32'hC2,32'h80000004,0,0, 1,0,0,0,          32'hC0000000,0,0);
        add(0,0,0,32'h80000004,0,0,      0,32'h4,2,32'hC2, 32'hC0000000,0,0);
        add(0,1,32'hC3,32'h80000004,0,32'hC0000004, 0,0,0,0, 32'hC0000004,0,0);
        add(0,0,0,32'h80000004,0,0,      1,0,0,0,          0,1,0);
        // spurious done: done=0x3 while busy=0x1
        add(1,0,0,M,0,0,                 0,0,0,0,          0,1,0);
        add(0,1,32'hD0,M,0,0,            1,0,0,0,          0,1,0);
        add(0,0,0,M,0,0,                 0,32'h1,0,32'hD0, 0,0,0);
        add(0,0,0,M,0,32'h3,             1,0,0,0,          32'h1,0,0);
        add(0,0,0,M,0,0,                 1,0,0,0,          0,1,1);
        add(0,0,0,M,0,0,                 1,0,0,0,          0,1,1);
        // drain blocks acceptance; an accepted job still issues under drain
        add(0,1,32'hE9,M,1,0,            0,0,0,0,          0,1,1);
        add(0,0,0,M,0,0,                 1,0,0,0,          0,1,1);
        add(0,1,32'hE0,M,0,0,            1,0,0,0,          0,1,1);
        add(0,1,32'hE1,M,1,0,            0,32'h2,1,32'hE0, 0,0,1);
        add(0,1,32'hE1,M,1,0,            0,0,0,0,          32'h2,0,1);
        // reset pulsed during the issue cycle
        add(1,0,0,M,0,0,                 0,0,0,0,          0,1,0);
        add(0,1,32'hF0,M,0,0,            1,0,0,0,          0,1,0);
        add(1,0,0,M,0,0,                 0,0,0,0,          0,1,0);
        add(0,0,0,M,0,0,                 1,0,0,0,          0,1,0);

        rst = 1'b1; job_valid = 1'b1; job_tag = 32'hDEAD; core_en_mask = M; drain = 1'b0; core_done = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_ready", {31'd0, job_ready}, 32'd0);
        chk("reset_idle", {31'd0, idle}, 32'd1);
        chk("reset_start", core_start, 32'd0);
        chk("reset_sel_tag", {core_tag[26:0], core_sel}, 32'd0);
        @(posedge clk); #1;

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; job_valid = vecs[i].jv; job_tag = vecs[i].tag;
            core_en_mask = vecs[i].mask; drain = vecs[i].drn; core_done = vecs[i].done;
            @(negedge clk);
            check_vec(i, vecs[i]);
            @(posedge clk); #1;
        end

        rst = 1'b0; job_valid = 1'b0; core_en_mask = M; drain = 1'b0; core_done = '0;
`ifdef ROMIX_SCHED_PERF_EN
        @(negedge clk);
        chk("perf_issued_after_rst", jobs_issued, 32'd0);
        chk("perf_done_after_rst", jobs_done, 32'd0);
        @(posedge clk); #1;
`endif

        // fill all 32 cores in round-robin order
        for (int i = 0; i < 32; i++) begin
            job_valid = 1'b1; job_tag = 32'h100 + i;
            @(negedge clk);
            chk("fill_ready", {31'd0, job_ready}, 32'd1);
            @(posedge clk); #1;
            job_valid = 1'b0;
            @(negedge clk);
            chk("fill_start", core_start, 32'h1 << i);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("full_busy", busy, M);
        chk("full_ready", {31'd0, job_ready}, 32'd0);
        @(posedge clk); #1;
        core_done = 32'h0000_0100;
        @(negedge clk);
        chk("done_cycle_ready", {31'd0, job_ready}, 32'd0);
        @(posedge clk); #1;
        core_done = '0;
        @(negedge clk);
        chk("after_done_ready", {31'd0, job_ready}, 32'd1);
        chk("after_done_busy", busy, 32'hFFFF_FEFF);
        job_valid = 1'b1; job_tag = 32'h55;
        @(posedge clk); #1;
        job_valid = 1'b0;
        @(negedge clk);
        chk("refill_start", core_start, 32'h0000_0100);
        chk("refill_sel", {27'd0, core_sel}, 32'd8);
        chk("refill_tag", core_tag, 32'h55);
        @(posedge clk); #1;
`ifdef ROMIX_SCHED_PERF_EN
        @(negedge clk);
        chk("perf_issued", jobs_issued, 32'd33);
        chk("perf_done", jobs_done, 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/romix_core_scheduler.md
# romix_core_scheduler

Dispatches incoming scrypt ROMix jobs onto a bank of 32 ROMix cores using round-robin selection over free, enabled cores. For each dispatched job it produces a one-hot, single-cycle start strobe and a latched job tag. It tracks per-core busy state from done strobes and sits between the job-ingress FIFO and the multi-core ROMix array.

## Interface
- `NUM_CORES`, 32: core count; fixed at 32 (5-bit index).
- `IDX_W`, 5: core index width.
- `TAG_W`, 32: job tag width.

- `clk`  in  1  single clock.
- `rst`  in  1  asynchronous, active-high reset.
- `job_valid`  in  1  job request.
- `job_ready`  out  1  scheduler can accept the job this cycle.
- `job_tag`  in  TAG_W  job identifier.
- `core_en_mask`  in  32  cores allowed to receive new jobs; quasi-static.
- `drain`  in  1  stop accepting jobs.
- `core_start`  out  32  one-hot start pulse (all zero otherwise).
- `core_tag`  out  TAG_W  tag for the started core, valid with `core_start`.
- `core_sel`  out  IDX_W  index of the started core, valid with `core_start`.
- `core_done`  in  32  per-core completion pulses; any number of bits may be set.
- `busy`  out  32  per-core busy flags.
- `idle`  out  1  no core busy and FSM in S_IDLE.
- `err_spurious_done`  out  1  sticky; set when `core_done[i]` arrives while `busy[i]`=0.

## Operation
- Free set: `F = ~busy & core_en_mask`.
- FSM states:
  - S_IDLE: `job_ready = (F != 0) & ~drain`. On `job_valid & job_ready`:
    - latch `job_tag`;
    - pick `sel` = first set bit of F searching upward from `ptr+1`, wrapping 31→0;
    - go to S_ISSUE.
  - S_ISSUE: assert `core_start[sel]` for one cycle. Drive `core_tag`/`core_sel`. Set `busy[sel]`, set `ptr <= sel`, return to S_IDLE. `job_ready` = 0.
- Done handling runs every cycle, independent of state:
  - `busy[i]` clears on `core_done[i]`.
  - A done on a core that is not busy sets `err_spurious_done` and leaves `busy[i]` at 0.
- Same-cycle set and clear on the same core (done arriving in the S_ISSUE cycle for `sel`) cannot occur legally because `sel` was free. If it does occur, set wins and the error flag is raised.
- Clearing a bit in `core_en_mask` never aborts a busy core. That core finishes normally and is not chosen again.
- `drain` deasserts `job_ready` only. A job accepted before drain still issues.
- Reset values: state S_IDLE, `busy`=0, `ptr`=31 (first grant goes to core 0), `core_start`=0, `core_tag`=0, `core_sel`=0, `err_spurious_done`=0, `job_ready`=0 during reset, `idle`=1 after reset.

## Timing
- Handshake to start latency is 1 cycle: accept in cycle N, `core_start` in cycle N+1.
- Maximum throughput is one job every 2 cycles.
- `busy[sel]` reads 1 from cycle N+2.
- A done in cycle M frees the core for selection in cycle M+1.
- `job_ready` is combinational from registered state, `busy`, `core_en_mask` and `drain`. There is no combinational path from `job_valid`.
- Asserting `rst` mid-operation clears everything immediately. In-flight jobs are lost, and cores are reset externally by the same `rst`.

## Configuration
- `ROMIX_SCHED_PERF_EN` defined: adds outputs `jobs_issued[31:0]` and `jobs_done[31:0]`.
  - Both are free-running wrap-around counters and reset to 0.
  - `jobs_issued` increments on each `core_start` cycle.
  - `jobs_done` increments by popcount of valid (busy) done bits.
- Not defined: the ports and counters are absent and behaviour is otherwise identical.

## Structure
- Package `romix_sched_pkg` holds `NUM_CORES`, `IDX_W`, the state enum (S_IDLE, S_ISSUE), and a one-hot-from-index function for the start decode.
- Sub-module `rr_pick_32` is combinational. Inputs: `F` and `ptr`. Outputs: `sel` and `any`. It is implemented as a rotate, priority encode, then un-rotate.

## Test plan
- Reset, all cores enabled, 3 back-to-back jobs with tags 0xA0..0xA2 → `core_start` = 0x1, 0x2, 0x4 on cycles 1, 3, 5 after the first accept, with matching tags; `busy`=0x7.
- Mask 0xFFFF_FFF0, ptr=31 → first job goes to core 4 (`core_start`=0x10).
- All 32 cores busy → `job_ready`=0. `core_done`=0x0000_0100 → `job_ready`=1 the next cycle, and the next job goes to core 8.
- Wrap: ptr=30, free {31, 2} → sel=31. The next job selects 2.
- `core_done`=0x3 while `busy`=0x1 → `busy`=0, `err_spurious_done`=1 and stays set.
- `rst` pulsed during S_ISSUE → `core_start`=0, `busy`=0, `idle`=1. With `ROMIX_SCHED_PERF_EN`, both counters read 0.
